// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Instruction-sequencing controller for a single-cycle MIPS datapath. Owns
// the program counter, fetches each instruction through a req/ack handshake
// with instruction memory, holds it for the datapath while it executes, and
// on completion selects the next PC (halt > jump > branch > sequential).
//
// Parameters
//   RESET_PC      PC loaded on reset (must be word-aligned)
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   fetch_req      out  fetch request (high in FETCH)
//   fetch_addr     out  fetch address, always equal to pc
//   fetch_ack      in   instr_in valid this cycle
//   instr_in       in   instruction word from memory
//   instr_out      out  latched instruction for the datapath
//   instr_valid    out  one-cycle pulse: instr_out updated this cycle
//   exec_done      in   datapath finished; redirect inputs valid
//   jump           in   current instruction is J/JAL
//   jump_field     in   instruction bits [25:0]
//   branch         in   branch taken
//   branch_offset  in   sign-extended immediate, in words
//   halt           in   stop sequencing after this instruction
//   pc             out  current program counter
//   pc_plus4       out  pc + 4 (mod 2^32)
//   retired        out  retired-instruction count (halting one excluded)
//   state          out  BOOT=0, FETCH=1, EXEC=2, HALT=3
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic [31:0] instr_in,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        jump,
    input  logic [25:0] jump_field,
    input  logic        branch,
    input  logic [31:0] branch_offset,
    input  logic        halt,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] seq_pc;

    // Sequential successor; wraps naturally at 2^32.
    assign seq_pc = pc_q + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            valid_q   <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = 1'b0;
        retired_d = retired_q;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (fetch_ack) begin
                    instr_d = instr_in;
                    valid_d = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exec_done) begin
                    if (halt) begin
                        // Halting instruction does not retire and pc holds.
                        state_d = ST_HALT;
                    end else begin
                        retired_d = retired_q + 32'd1;
                        state_d   = ST_FETCH;
                        if (jump) begin
                            pc_d = {seq_pc[31:28], jump_field, 2'b00};
                        end else if (branch) begin
                            // Word offset scaled to bytes; upper bits drop out.
                            pc_d = seq_pc + (branch_offset << 2);
                        end else begin
                            pc_d = seq_pc;
                        end
                    end
                end
            end
            ST_HALT: begin
                // Terminal: only reset leaves this state.
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // All outputs come straight from registers (no input-to-output paths).
    assign fetch_req   = (state_q == ST_FETCH);
    assign fetch_addr  = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = seq_pc;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign retired     = retired_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        fetch_ack;
    logic [31:0] instr_in;
    logic        exec_done;
    logic        jump;
    logic [25:0] jump_field;
    logic        branch;
    logic [31:0] branch_offset;
    logic        halt;

    logic        fetch_req, fetch_req2;
    logic [31:0] fetch_addr, fetch_addr2;
    logic [31:0] instr_out, instr_out2;
    logic        instr_valid, instr_valid2;
    logic [31:0] pc, pc2;
    logic [31:0] pc_plus4, pc_plus42;
    logic [31:0] retired, retired2;
    logic [1:0]  state, state2;

    int total = 0;
    int bad   = 0;

    pc_sequencer #(.RESET_PC(32'h0040_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ack(fetch_ack), .instr_in(instr_in),
        .instr_out(instr_out), .instr_valid(instr_valid),
        .exec_done(exec_done), .jump(jump), .jump_field(jump_field),
        .branch(branch), .branch_offset(branch_offset), .halt(halt),
        .pc(pc), .pc_plus4(pc_plus4), .retired(retired), .state(state)
    );

    // Second instance sharing the stimulus, used for the top-of-memory wrap.
    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req2), .fetch_addr(fetch_addr2),
        .fetch_ack(fetch_ack), .instr_in(instr_in),
        .instr_out(instr_out2), .instr_valid(instr_valid2),
        .exec_done(exec_done), .jump(jump), .jump_field(jump_field),
        .branch(branch), .branch_offset(branch_offset), .halt(halt),
        .pc(pc2), .pc_plus4(pc_plus42), .retired(retired2), .state(state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: next PC from the architectural rules, in plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic j,
                                             input logic [25:0] jf, input logic b,
                                             input logic [31:0] off);
        logic [31:0] seq;
        logic [31:0] jf32;
        seq  = cur + 32'd4;
        jf32 = {6'd0, jf};
        if (j)      return (seq & 32'hF000_0000) | (jf32 * 32'd4);
        else if (b) return seq + off * 32'd4;
        else        return seq;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic idle_inputs();
        fetch_ack = 0; exec_done = 0; jump = 0; branch = 0; halt = 0;
        jump_field = '0; branch_offset = '0;
    endtask

    // From FETCH: acknowledge with the given word (one edge).
    task automatic do_fetch(input logic [31:0] w);
        fetch_ack = 1; instr_in = w;
        tick();
        fetch_ack = 0;
    endtask

    // From EXEC: complete with the given redirect (one edge).
    task automatic do_exec(input logic j, input logic [25:0] jf, input logic b,
                           input logic [31:0] off, input logic h);
        exec_done = 1; jump = j; jump_field = jf; branch = b; branch_offset = off; halt = h;
        tick();
        idle_inputs();
    endtask

    typedef struct {
        string       name;
        logic [31:0] start_pc;
        logic        j;
        logic [25:0] jf;
        logic        b;
        logic [31:0] off;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[7];

    logic [31:0] m_pc;
    logic [31:0] m_ret;

    initial begin
        vecs[0] = '{"jump_concat",   32'hF000_0010, 1, 26'h000_0040, 0, 32'h0,         32'hF000_0100};
        vecs[1] = '{"jump_priority", 32'hF000_0010, 1, 26'h000_0040, 1, 32'h5,         32'hF000_0100};
        vecs[2] = '{"branch_self",   32'h0000_0100, 0, 26'h0,        1, 32'hFFFF_FFFF, 32'h0000_0100};
        vecs[3] = '{"sequential",    32'h0000_1234, 0, 26'h0,        0, 32'h0,         32'h0000_1238};
        vecs[4] = '{"branch_fwd",    32'h0000_1000, 0, 26'h0,        1, 32'h10,        32'h0000_1044};
        vecs[5] = '{"jump_nibble",   32'h7FFF_FFFC, 1, 26'h3FF_FFFF, 0, 32'h0,         32'h8FFF_FFFC};
        vecs[6] = '{"branch_wrap",   32'hFFFF_FFFC, 0, 26'h0,        1, 32'h1,         32'h0000_0004};

        idle_inputs();
        instr_in = 32'h0;
        rst_n = 0;

        // ---- reset / boot ----
        repeat (3) tick();
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
        chk("rst_pc", pc, 32'h0040_0000);
        chk("rst_retired", retired, 32'd0);
        chk("rst_instr_out", instr_out, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);

        rst_n = 1; fetch_ack = 1; exec_done = 1; instr_in = 32'hA000_0000;
        tick();                                   // BOOT -> FETCH
        for (int i = 0; i < 3; i++) begin
            chk("boot_fetch_addr", fetch_addr, 32'h0040_0000 + 32'(4 * i));
            chk("boot_fetch_req", {31'd0, fetch_req}, 32'd1);
            tick();                               // FETCH -> EXEC
            chk("boot_valid", {31'd0, instr_valid}, 32'd1);
            chk("boot_instr", instr_out, 32'hA000_0000 + 32'(i));
            instr_in = 32'hA000_0001 + 32'(i);
            tick();                               // EXEC -> FETCH
            chk("boot_retired", retired, 32'(i + 1));
            if (i == 0) chk("wrap_seq_pc", pc2, 32'h0000_0000);
        end
        idle_inputs();
        m_pc = 32'h0040_000C; m_ret = 32'd3;

        // ---- fetch wait ----
        for (int i = 0; i < 5; i++) begin
            chk("wait_state", {30'd0, state}, 32'd1);
            chk("wait_req", {31'd0, fetch_req}, 32'd1);
            tick();
        end
        do_fetch(32'h2108_0001);
        chk("wait_instr", instr_out, 32'h2108_0001);
        chk("wait_valid", {31'd0, instr_valid}, 32'd1);
        chk("wait_state_exec", {30'd0, state}, 32'd2);
        tick();
        chk("wait_valid_once", {31'd0, instr_valid}, 32'd0);

        // ---- table of redirects; each vector first branches to its start pc ----
        for (int v = 0; v < 7; v++) begin
            do_exec(0, '0, 1, (vecs[v].start_pc - (m_pc + 32'd4)) >> 2, 0);
            m_pc = vecs[v].start_pc; m_ret++;
            chk({vecs[v].name, "_start"}, fetch_addr, m_pc);
            do_fetch(32'h1000_0000 + 32'(v));
            do_exec(vecs[v].j, vecs[v].jf, vecs[v].b, vecs[v].off, 0);
            m_pc = vecs[v].exp_pc; m_ret++;
            chk(vecs[v].name, fetch_addr, vecs[v].exp_pc);
            chk({vecs[v].name, "_plus4"}, pc_plus4, vecs[v].exp_pc + 32'd4);
            chk({vecs[v].name, "_retired"}, retired, m_ret);
            do_fetch(32'h2000_0000 + 32'(v));     // back into EXEC for next vector
        end
        do_exec(0, '0, 0, '0, 0);
        m_pc = m_pc + 32'd4; m_ret++;

        // ---- randomized instructions vs reference ----
        for (int n = 0; n < 40; n++) begin
            logic [31:0] w, off;
            logic [25:0] jf;
            logic        j, b;
            int          fw, ew;
            chk("rnd_fetch_addr", fetch_addr, m_pc);
            fw = $urandom_range(0, 3);
            for (int k = 0; k < fw; k++) begin
                fetch_ack = 0; exec_done = 1'($urandom); halt = 1'($urandom);
                jump = 1'($urandom); branch = 1'($urandom); branch_offset = $urandom;
                tick();
            end
            idle_inputs();
            chk("rnd_fetch_state", {30'd0, state}, 32'd1);
            w = $urandom;
            do_fetch(w);
            chk("rnd_instr", instr_out, w);
            chk("rnd_valid", {31'd0, instr_valid}, 32'd1);
            j = 1'($urandom); b = 1'($urandom); jf = 26'($urandom); off = $urandom;
            ew = $urandom_range(0, 3);
            for (int k = 0; k < ew; k++) begin
                exec_done = 0; fetch_ack = 1'($urandom); halt = 1'($urandom);
                jump = j; branch = b; jump_field = jf; branch_offset = off;
                tick();
            end
            idle_inputs();
            chk("rnd_exec_state", {30'd0, state}, 32'd2);
            do_exec(j, jf, b, off, 0);
            m_pc = ref_next(m_pc, j, jf, b, off); m_ret++;
            chk("rnd_pc", pc, m_pc);
            chk("rnd_retired", retired, m_ret);
        end

        // ---- reset asserted mid-FETCH, while awaiting ack ----
        instr_in = 32'hDEAD_BEEF;
        tick();
        rst_n = 0;
        #1;
        chk("midrst_state", {30'd0, state}, 32'd0);
        chk("midrst_pc", pc, 32'h0040_0000);
        chk("midrst_retired", retired, 32'd0);
        chk("midrst_instr", instr_out, 32'd0);
        chk("midrst_req", {31'd0, fetch_req}, 32'd0);
        chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
        fetch_ack = 1;                            // pending response must be dropped
        tick(); tick();
        fetch_ack = 0;
        rst_n = 1;
        chk("midrst_boot", {30'd0, state}, 32'd0);
        tick();

        // ---- halt after two retired instructions ----
        for (int i = 0; i < 2; i++) begin
            do_fetch(32'h3000_0000);
            do_exec(0, '0, 0, '0, 0);
        end
        do_fetch(32'h3000_0001);
        do_exec(1, 26'h123, 1, 32'h40, 1);
        chk("halt_state", {30'd0, state}, 32'd3);
        chk("halt_pc", pc, 32'h0040_0008);
        chk("halt_retired", retired, 32'd2);
        for (int k = 0; k < 4; k++) begin
            fetch_ack = 1'(k % 2 == 0); exec_done = 1; jump = 1; instr_in = $urandom;
            tick();
        end
        idle_inputs();
        chk("halt_hold_state", {30'd0, state}, 32'd3);
        chk("halt_hold_pc", pc, 32'h0040_0008);
        chk("halt_hold_retired", retired, 32'd2);
        chk("halt_hold_req", {31'd0, fetch_req}, 32'd0);
        chk("halt_hold_valid", {31'd0, instr_valid}, 32'd0);
        chk("halt_hold_instr", instr_out, 32'h3000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-sequencing controller for the single-cycle MIPS datapath. Owns the program counter and fetches each instruction through a request/acknowledge handshake with instruction memory. It holds the instruction while the datapath executes it. On completion it selects the next PC: sequential (PC+4), branch target, or jump target formed by concatenating the upper PC+4 nibble with the 26-bit jump field. It sits between instruction memory and the control/ALU datapath and replaces the free-running PC register plus next-PC mux.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned (bits [1:0] = 0).
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- fetch_req  out  1  instruction fetch request to instruction memory.
- fetch_addr  out  32  fetch address; equals pc.
- fetch_ack  in  1  memory has instr_in valid this cycle.
- instr_in  in  32  instruction word from memory.
- instr_out  out  32  latched instruction presented to the datapath.
- instr_valid  out  1  one-cycle pulse: instr_out was updated this cycle.
- exec_done  in  1  datapath finished the current instruction; redirect inputs are valid.
- jump  in  1  current instruction is J/JAL.
- jump_field  in  26  instruction bits [25:0].
- branch  in  1  branch taken.
- branch_offset  in  32  sign-extended 16-bit immediate, in words.
- halt  in  1  stop sequencing after this instruction.
- pc  out  32  current program counter.
- pc_plus4  out  32  pc + 4 mod 2^32 (combinational).
- retired  out  32  count of instructions retired, excluding the halting one.
- state  out  2  BOOT=0, FETCH=1, EXEC=2, HALT=3.

## Operation
- **BOOT:** fetch_req=0. Unconditionally advances to FETCH on the next edge.
- **FETCH:** fetch_req=1, fetch_addr=pc.
  - On a clock edge with fetch_ack=1: instr_out <= instr_in, instr_valid is high for the following cycle, and state advances to EXEC.
  - Without fetch_ack the state remains FETCH; wait length is unbounded.
- **EXEC:** fetch_req=0. Waits for exec_done=1, then updates pc using this priority: halt > jump > branch > sequential.
  - **halt:** pc unchanged, retired unchanged, state goes to HALT.
  - **jump:** pc <= {pc_plus4[31:28], jump_field, 2'b00}; retired += 1; state goes to FETCH.
  - **branch:** pc <= pc_plus4 + (branch_offset << 2), truncated to 32 bits; retired += 1; state goes to FETCH.
  - **otherwise:** pc <= pc_plus4; retired += 1; state goes to FETCH.
- **HALT:** terminal. fetch_req=0. All inputs are ignored; only rst_n exits this state.
- **Ignored inputs:**
  - fetch_ack outside FETCH.
  - exec_done, jump, branch, halt and jump_field outside EXEC.
- **Arithmetic:** all adds are modulo 2^32. 0xFFFF_FFFC + 4 = 0x0000_0000. retired wraps 0xFFFF_FFFF -> 0.
- **Alignment:** pc[1:0] stays 0 for every path.

## Timing
- **Reset values (immediate on rst_n=0, independent of clk):** state=BOOT, pc=RESET_PC, instr_out=0, instr_valid=0, fetch_req=0, retired=0.
- **Minimum per-instruction loop, with fetch_ack and exec_done both high on first opportunity:** 2 cycles (FETCH, EXEC). The extra BOOT cycle occurs only after reset.
- A single-cycle combinational ack is legal: fetch_ack high in the first FETCH cycle completes the fetch at that edge.
- pc updates at the same edge that leaves EXEC. fetch_addr shows the new pc in the first cycle of the following FETCH.
- **Simultaneous events:**
  - jump+branch: jump wins.
  - halt with either redirect: halt wins and pc holds.
- **Reset mid-operation:** asserting rst_n in any state, including while awaiting fetch_ack, aborts the operation. The pending memory response is discarded. After deassertion, sequencing restarts from BOOT.
- Outputs pc, state, instr_out, instr_valid and retired are registered. fetch_req, fetch_addr and pc_plus4 are decoded from registers only, with no input-to-output combinational path.

## Test plan
- **Reset/boot:**
  - Stimulus: RESET_PC=0x0040_0000. Hold rst_n=0 for 3 cycles, release, tie fetch_ack=1 and exec_done=1.
  - Required: during reset, state=0 and fetch_req=0. Then fetch_addr runs 0x0040_0000, 0x0040_0004, 0x0040_0008 with one instr_valid pulse per fetch, and retired increments per EXEC.
- **Fetch wait:**
  - Stimulus: hold fetch_ack=0 for 5 cycles, then ack with instr_in=0x2108_0001.
  - Required: state=FETCH throughout with fetch_req=1. Then instr_out=0x2108_0001 and instr_valid pulses exactly once.
- **Jump concat:**
  - Stimulus: pc=0xF000_0010, jump=1, jump_field=26'h000_0040, exec_done=1.
  - Required: next fetch_addr=0xF000_0100.
- **Jump priority:**
  - Stimulus: same state as the jump-concat test, also branch=1.
  - Required: next fetch_addr=0xF000_0100.
- **Branch and wrap:**
  - Stimulus 1: pc=0x0000_0100, branch=1, offset=0xFFFF_FFFF. Required: pc=0x0000_0100 (self-loop).
  - Stimulus 2: RESET_PC=0xFFFF_FFFC, sequential step. Required: pc=0x0000_0000.
- **Halt and mid-op reset:**
  - Stimulus: after 2 retired instructions, assert halt with exec_done.
  - Required: state=HALT, pc unchanged, retired=2, and fetch_ack pulses are then ignored.
  - Stimulus: assert rst_n=0 mid-FETCH.
  - Required: all outputs show reset values within the same cycle.
